// File: rtl/fifo_ctrl_dp.sv
// fifo_ctrl_dp: sequences a two-port RAM as a synchronous FIFO.
// Port A is the write port, port B is the read port.
// Optional macro FIFO_STICKY_ERR_EN: error flags latch until reset instead of pulsing.
module fifo_ctrl_dp #(
  parameter int unsigned AW        = 3,
  parameter int unsigned DW        = 4,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          push,
  input  logic [DW-1:0] data_in,
  input  logic          pop,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [AW:0]   fifo_count,
  output logic          err_overflow,
  output logic          err_underflow,
  output logic [AW-1:0] mem_addr_a,
  output logic          mem_rw_a,
  output logic [DW-1:0] mem_data_a,
  output logic [AW-1:0] mem_addr_b,
  output logic          mem_rw_b,
  input  logic [DW-1:0] mem_data_b
);

  localparam logic [AW:0] DEPTH_LVL = (AW+1)'(1 << AW);
  localparam logic [AW:0] AF_LVL    = (AW+1)'(AF_THRESH);
  localparam logic [AW:0] AE_LVL    = (AW+1)'(AE_THRESH);

  typedef enum logic [1:0] {ST_EMPTY, ST_ACTIVE, ST_FULL} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          push_ok, pop_ok;
  logic          ovf_req, udf_req;

  // Request acceptance; a push into a full FIFO is allowed only alongside a pop.
  always_comb begin
    pop_ok    = pop & ~empty;
    push_ok   = push & (~full | pop_ok);
    ovf_req   = push & full & ~pop_ok;
    udf_req   = pop & empty;
    count_nxt = count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
  end

  // Level state register, kept in step with the occupancy count.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state <= ST_EMPTY;
    else          state <= state_nxt;
  end

  // Next level state follows the next occupancy value.
  always_comb begin
    state_nxt = ST_ACTIVE;
    if (count_nxt == '0)            state_nxt = ST_EMPTY;
    else if (count_nxt == DEPTH_LVL) state_nxt = ST_FULL;
  end

  // Status outputs decoded from the level state and the count register.
  always_comb begin
    empty        = (state == ST_EMPTY);
    full         = (state == ST_FULL);
    almost_full  = (count >= AF_LVL);
    almost_empty = (count <= AE_LVL);
    fifo_count   = count;
  end

  // Pointers, occupancy and read-valid pipeline.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      valid_out <= pop_ok;
    end
  end

  // Error flags: one-cycle pulse per rejected request, or latched until reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
`ifdef FIFO_STICKY_ERR_EN
      err_overflow  <= err_overflow  | ovf_req;
      err_underflow <= err_underflow | udf_req;
`else
      err_overflow  <= ovf_req;
      err_underflow <= udf_req;
`endif
    end
  end

  // RAM port wiring; port B reads every cycle, its registered word is the FIFO output.
  always_comb begin
    mem_addr_a = wr_ptr;
    mem_rw_a   = push_ok;
    mem_data_a = data_in;
    mem_addr_b = rd_ptr;
    mem_rw_b   = 1'b0;
    data_out   = mem_data_b;
  end

endmodule

// File: tb/tb_fifo_ctrl_dp.sv
// Bench for fifo_ctrl_dp: a behavioural RAM next to the DUT, a queue-based
// FIFO model checked every cycle, plus literal expectations at key points.
module tb_fifo_ctrl_dp;

  localparam int DEPTH = 8;

`ifdef FIFO_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_L = 1'b0;
  logic       push = 1'b0;
  logic [3:0] data_in = '0;
  logic       pop = 1'b0;
  logic [3:0] data_out;
  logic       valid_out, full, empty, almost_full, almost_empty;
  logic [3:0] fifo_count;
  logic       err_overflow, err_underflow;
  logic [2:0] mem_addr_a, mem_addr_b;
  logic       mem_rw_a, mem_rw_b;
  logic [3:0] mem_data_a, mem_data_b;

  fifo_ctrl_dp #(.AW(3), .DW(4), .AF_THRESH(6), .AE_THRESH(2)) dut (
    .clk(clk), .reset_L(reset_L), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .valid_out(valid_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .fifo_count(fifo_count),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .mem_addr_a(mem_addr_a), .mem_rw_a(mem_rw_a), .mem_data_a(mem_data_a),
    .mem_addr_b(mem_addr_b), .mem_rw_b(mem_rw_b), .mem_data_b(mem_data_b)
  );

  always #5 clk = ~clk;

  // Two-port RAM: port A writes, port B registered read, read-before-write.
  logic [3:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_rw_a) ram[mem_addr_a] <= mem_data_a;
    mem_data_b <= ram[mem_addr_b];
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // FIFO model: queue of stored words plus push/pop totals for RAM addresses.
  logic [3:0] q[$];
  int  n_push, n_pop;
  bit  exp_valid, exp_eo, exp_eu;
  logic [3:0] exp_data;

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      q.delete();
      n_push = 0; n_pop = 0;
      exp_valid = 0; exp_eo = 0; exp_eu = 0; exp_data = '0;
    end else begin
      bit p_ok, w_ok, ov, un;
      p_ok = pop && q.size() > 0;
      w_ok = push && (q.size() < DEPTH || p_ok);
      ov   = push && q.size() == DEPTH && !p_ok;
      un   = pop && q.size() == 0;
      exp_eo = STICKY ? (exp_eo | ov) : ov;
      exp_eu = STICKY ? (exp_eu | un) : un;
      exp_valid = p_ok;
      if (p_ok) begin exp_data = q.pop_front(); n_pop++; end
      if (w_ok) begin q.push_back(data_in); n_push++; end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int sz;
    bit w_ok;
    sz   = q.size();
    w_ok = push && (sz < DEPTH || (pop && sz > 0));
    chk("fifo_count", int'(fifo_count), sz);
    chk("empty", int'(empty), int'(sz == 0));
    chk("full", int'(full), int'(sz == DEPTH));
    chk("almost_full", int'(almost_full), int'(sz >= 6));
    chk("almost_empty", int'(almost_empty), int'(sz <= 2));
    chk("valid_out", int'(valid_out), int'(exp_valid));
    if (exp_valid) chk("data_out", int'(data_out), int'(exp_data));
    chk("err_overflow", int'(err_overflow), int'(exp_eo));
    chk("err_underflow", int'(err_underflow), int'(exp_eu));
    chk("mem_rw_a", int'(mem_rw_a), int'(w_ok));
    chk("mem_addr_a", int'(mem_addr_a), n_push % DEPTH);
    chk("mem_addr_b", int'(mem_addr_b), n_pop % DEPTH);
    chk("mem_data_a", int'(mem_data_a), int'(data_in));
    chk("mem_rw_b", int'(mem_rw_b), 0);
  end

  // One clock of stimulus; returns 1 time unit after the edge.
  task automatic step(input bit p, input logic [3:0] d, input bit r);
    push = p; data_in = d; pop = r;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; data_in = '0;
  endtask

  initial begin
    logic [3:0] drain [8];
    drain = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hA};

    // Reset then idle.
    #22 reset_L = 1'b1;
    @(posedge clk); #1;
    chk("lit_reset_empty", int'(empty), 1);
    chk("lit_reset_count", int'(fifo_count), 0);

    // Reset asserted mid-burst with a read in flight.
    step(1, 4'h1, 0);
    step(1, 4'h2, 0);
    step(1, 4'h3, 1);
    chk("lit_burst_valid", int'(valid_out), 1);
    chk("lit_burst_count", int'(fifo_count), 2);
    #2 reset_L = 1'b0;
    #1;
    chk("lit_arst_count", int'(fifo_count), 0);
    chk("lit_arst_empty", int'(empty), 1);
    chk("lit_arst_aempty", int'(almost_empty), 1);
    chk("lit_arst_valid", int'(valid_out), 0);
    chk("lit_arst_err", int'(err_overflow) + int'(err_underflow), 0);
    #3 reset_L = 1'b1;
    @(posedge clk); #1;

    // Fill with 1..8.
    for (int i = 1; i <= 8; i++) begin
      step(1, 4'(i), 0);
      if (i == 5) chk("lit_af_at5", int'(almost_full), 0);
      if (i == 6) chk("lit_af_at6", int'(almost_full), 1);
    end
    chk("lit_fill_count", int'(fifo_count), 8);
    chk("lit_fill_full", int'(full), 1);

    // Overflow attempt.
    step(1, 4'h9, 0);
    chk("lit_ovf_pulse", int'(err_overflow), 1);
    chk("lit_ovf_count", int'(fifo_count), 8);

    // Full with simultaneous push and pop: oldest word out, count unchanged.
    step(1, 4'hA, 1);
    chk("lit_fullpp_data", int'(data_out), 1);
    chk("lit_fullpp_count", int'(fifo_count), 8);
    chk("lit_fullpp_ovf", int'(err_overflow), int'(STICKY));

    // Drain: remaining words in order, 0xA last after the wrap.
    for (int i = 0; i < 8; i++) begin
      step(0, 4'h0, 1);
      chk("lit_drain_valid", int'(valid_out), 1);
      chk("lit_drain_data", int'(data_out), int'(drain[i]));
    end
    chk("lit_drain_empty", int'(empty), 1);

    // Pop on empty.
    step(0, 4'h0, 1);
    chk("lit_udf_pulse", int'(err_underflow), 1);
    chk("lit_udf_valid", int'(valid_out), 0);
    step(0, 4'h0, 0);

    // Push and pop together while empty.
    step(1, 4'h3, 1);
    chk("lit_epp_count", int'(fifo_count), 1);
    chk("lit_epp_udf", int'(err_underflow), 1);
    step(0, 4'h0, 1);
    chk("lit_epp_data", int'(data_out), 3);
    chk("lit_epp_valid", int'(valid_out), 1);

    // Mixed traffic around the thresholds.
    for (int i = 0; i < 12; i++) step(1, 4'(i + 4), (i % 3) == 2);
    for (int i = 0; i < 10; i++) step((i % 2) == 0, 4'(15 - i), 1);
    step(0, 4'h0, 0);
    step(0, 4'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_dp.md
Name: fifo_ctrl_dp

Overview:
- Controller that sequences the team's two-port RAM (AW address bits, DW data bits, 2**AW words) as a synchronous FIFO.
- Port A of the RAM is used only as the write port; port B only as the read port.
- Exposes a push/pop interface, occupancy count and status flags to the upstream/downstream logic.
- Pure control: the storage array lives in the RAM instance, wired beside this block in the parent.

Parameters:
AW, 3, RAM address width; FIFO depth DEPTH = 2**AW.
DW, 4, data width.
AF_THRESH, 6, almost_full asserted when count >= AF_THRESH.
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH.

Ports:
clk  input  1  single clock, all state on posedge.
reset_L  input  1  asynchronous active-low reset.
push  input  1  write request, data on data_in.
data_in  input  DW  write data.
pop  input  1  read request.
data_out  output  DW  read data, valid when valid_out=1.
valid_out  output  1  registered; high the cycle after an accepted pop.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AF_THRESH.
almost_empty  output  1  count <= AE_THRESH.
fifo_count  output  AW+1  current occupancy, 0..DEPTH.
err_overflow  output  1  push rejected because full.
err_underflow  output  1  pop rejected because empty.
mem_addr_a  output  AW  RAM port A address = wr_ptr.
mem_rw_a  output  1  RAM port A mode, 1 = write, 0 = read; equals push_ok.
mem_data_a  output  DW  RAM port A write data = data_in.
mem_addr_b  output  AW  RAM port B address = rd_ptr.
mem_rw_b  output  1  RAM port B mode, tied 0 (read only).
mem_data_b  input  DW  RAM port B registered read data.

Behaviour:
- Reset (reset_L=0, asynchronous, any cycle):
  - wr_ptr=0, rd_ptr=0, count=0, valid_out=0, err_overflow=0, err_underflow=0.
  - Flags follow count: empty=1, almost_empty=1, full=0, almost_full=0.
  - In-flight read is discarded; RAM contents are don't-care after reset.
- Acceptance (combinational):
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | pop_ok).
- State derived from count:
  - EMPTY (0): pop rejected; push only.
  - ACTIVE (1..DEPTH-1): push and pop both accepted.
  - FULL (DEPTH): push accepted only together with an accepted pop.
- On posedge:
  - push_ok: wr_ptr <= wr_ptr+1, mod DEPTH, natural AW-bit wrap.
  - pop_ok: rd_ptr <= rd_ptr+1, mod DEPTH.
  - count <= count + push_ok - pop_ok; push and pop together leave count unchanged.
- Write latency: the RAM captures data_in at the same edge that push_ok is sampled.
- Read latency: 1 cycle.
  - RAM registers port B at the pop_ok edge.
  - valid_out <= pop_ok.
  - data_out = mem_data_b, combinational pass-through.
  - data_out is undefined when valid_out=0.
- Full with push+pop: wr_ptr == rd_ptr, and port A writes the same address port B reads. The read returns the old word (RAM read-before-write at the shared edge), which is the required behaviour.
- Empty with push+pop: pop rejected and err_underflow raised; push accepted; count becomes 1.
- Flags and fifo_count are combinational from the count register; there is no extra latency.
- Error flags (default build):
  - Registered one-cycle pulse the cycle after the offending request.
  - err_overflow <= push & full & ~pop_ok.
  - err_underflow <= pop & empty.
  - Rejected requests change no state.

Optional Feature:
- Macro: FIFO_STICKY_ERR_EN.
- Defined: err_overflow and err_underflow latch high on the first offending request and stay high until reset_L is asserted.
- Not defined: one-cycle pulse per offending request, as described in Behaviour.

Test Plan:
- Reset then idle: reset_L low mid-burst -> empty=1, almost_empty=1, fifo_count=0, valid_out=0, errors 0.
- Push 0x1..0x8 on 8 consecutive cycles -> fifo_count=8, full=1, almost_full=1 from count 6; mem_rw_a=1 each cycle; mem_addr_a 0..7.
- Pop 8 times -> data_out 0x1..0x8, each with valid_out=1 one cycle after its pop; empty=1 after the eighth pop; rd_ptr wraps to 0.
- Full plus extra push (0x9) with no pop -> err_overflow pulse; count stays 8; the next pops still return 0x1.
- Full plus simultaneous push 0xA and pop -> data_out=oldest word, count stays 8, no error; after a wrap, 0xA is eventually read out in order.
- Empty plus pop -> err_underflow (pulse, or sticky with FIFO_STICKY_ERR_EN), valid_out stays 0.
- Empty plus push 0x3 and pop together -> count=1, err_underflow=1, next pop returns 0x3.
